id_ex_hazard_reg: RTL

//  ID/EX pipeline register with integrated load-use hazard detection. It captures

---
 rtl/id_ex_hazard_reg.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded ID fields for EX, inserts bubbles on load-use hazards,
// branch flush or when ID is empty, and freezes on a backend stall.
module id_ex_hazard_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [DATA_WIDTH-1:0]     id_pc_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     id_imm_i,
  input  logic [ALU_OP_WIDTH-1:0]   id_alu_op_i,
  input  logic                      id_alu_src_i,
  input  logic                      id_reg_write_i,
  input  logic                      id_mem_read_i,
  input  logic                      id_mem_write_i,
  input  logic                      id_branch_i,
  input  logic                      flush_i,
  input  logic                      ext_stall_i,
  output logic                      stall_o,
  output logic                      ex_valid_o,
  output logic [DATA_WIDTH-1:0]     ex_pc_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data_o,
  output logic [DATA_WIDTH-1:0]     ex_imm_o,
  output logic [ALU_OP_WIDTH-1:0]   ex_alu_op_o,
  output logic                      ex_alu_src_o,
  output logic                      ex_reg_write_o,
  output logic                      ex_mem_read_o,
  output logic                      ex_mem_write_o,
  output logic                      ex_branch_o,
  output logic [CNT_WIDTH-1:0]      bubble_cnt_o
);

  logic                      ex_valid_reg;
  logic [DATA_WIDTH-1:0]     ex_pc_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_reg;
  logic [DATA_WIDTH-1:0]     ex_rs1_data_reg;
  logic [DATA_WIDTH-1:0]     ex_rs2_data_reg;
  logic [DATA_WIDTH-1:0]     ex_imm_reg;
  logic [ALU_OP_WIDTH-1:0]   ex_alu_op_reg;
  logic                      ex_alu_src_reg;
  logic                      ex_reg_write_reg;
  logic                      ex_mem_read_reg;
  logic                      ex_mem_write_reg;
  logic                      ex_branch_reg;
  logic [CNT_WIDTH-1:0]      bubble_cnt_reg;

  logic hazard;
  logic load_bubble;
  logic capture;
  logic count_bubble;

  // Load-use detection against the instruction currently in EX, plus update selects.
  always_comb begin
    hazard = ex_valid_reg & ex_mem_read_reg & (ex_rd_reg != '0) & id_valid_i &
             ((id_rs1_used_i & (id_rs1_i == ex_rd_reg)) |
              (id_rs2_used_i & (id_rs2_i == ex_rd_reg)));
    // Flush squashes ID, so it never needs a hold upstream.
    stall_o      = (hazard | ext_stall_i) & ~flush_i;
    load_bubble  = rst_i | flush_i | (~ext_stall_i & (hazard | ~id_valid_i));
    capture      = ~rst_i & ~flush_i & ~ext_stall_i & ~hazard & id_valid_i;
    count_bubble = ~flush_i & ~ext_stall_i & hazard & (bubble_cnt_reg != '1);
  end

  // Pipeline register: bubble, capture, or hold (backend freeze).
  always_ff @(posedge clk_i) begin
    if (load_bubble) begin
      ex_valid_reg     <= 1'b0;
      ex_pc_reg        <= '0;
      ex_rs1_reg       <= '0;
      ex_rs2_reg       <= '0;
      ex_rd_reg        <= '0;
      ex_rs1_data_reg  <= '0;
      ex_rs2_data_reg  <= '0;
      ex_imm_reg       <= '0;
      ex_alu_op_reg    <= '0;
      ex_alu_src_reg   <= 1'b0;
      ex_reg_write_reg <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      ex_mem_write_reg <= 1'b0;
      ex_branch_reg    <= 1'b0;
    end else if (capture) begin
      ex_valid_reg     <= 1'b1;
      ex_pc_reg        <= id_pc_i;
      ex_rs1_reg       <= id_rs1_i;
      ex_rs2_reg       <= id_rs2_i;
      ex_rd_reg        <= id_rd_i;
      ex_rs1_data_reg  <= id_rs1_data_i;
      ex_rs2_data_reg  <= id_rs2_data_i;
      ex_imm_reg       <= id_imm_i;
      ex_alu_op_reg    <= id_alu_op_i;
      ex_alu_src_reg   <= id_alu_src_i;
      ex_reg_write_reg <= id_reg_write_i;
      ex_mem_read_reg  <= id_mem_read_i;
      ex_mem_write_reg <= id_mem_write_i;
      ex_branch_reg    <= id_branch_i;
    end
  end

  // Saturating count of load-use bubbles; flush does not clear it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_reg <= '0;
    end else if (count_bubble) begin
      bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
    end
  end

  assign ex_valid_o     = ex_valid_reg;
  assign ex_pc_o        = ex_pc_reg;
  assign ex_rs1_o       = ex_rs1_reg;
  assign ex_rs2_o       = ex_rs2_reg;
  assign ex_rd_o        = ex_rd_reg;
  assign ex_rs1_data_o  = ex_rs1_data_reg;
  assign ex_rs2_data_o  = ex_rs2_data_reg;
  assign ex_imm_o       = ex_imm_reg;
  assign ex_alu_op_o    = ex_alu_op_reg;
  assign ex_alu_src_o   = ex_alu_src_reg;
  assign ex_reg_write_o = ex_reg_write_reg;
  assign ex_mem_read_o  = ex_mem_read_reg;
  assign ex_mem_write_o = ex_mem_write_reg;
  assign ex_branch_o    = ex_branch_reg;
  assign bubble_cnt_o   = bubble_cnt_reg;

endmodule
